// File: rtl/axo_mem_sram_ctrl.sv
// axo_mem_sram_ctrl: connects one axo_mem_bus target port to an external
// single-port synchronous SRAM. The SRAM has 32-bit words, four byte-lane
// write enables and one cycle of read latency.
//
// Writes complete in the same cycle they are presented (no wait states).
// Reads take two cycles: the SRAM is strobed in the first cycle, and the
// lane-steered data is returned in the second cycle.
// A misaligned access, an illegal size, an address out of range, or re and
// we asserted together all complete at once with bus_error and make no
// SRAM access.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | accept a request; writes and errors complete here
// RDWAIT | SRAM read data valid; return it if the master still holds re
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   bus_re/we    read/write request, held by the master until bus_ready
//   bus_asize    0=byte 1=half 2=word 3=illegal
//   bus_addr     byte address local to this target
//   bus_wdata    right-aligned write data
//   bus_rdata    right-aligned, zero-extended read data
//   bus_ready    transfer completes this cycle
//   bus_error    transfer completes with error
//   sram_*       SRAM strobe, lane enables, word address, data
module axo_mem_sram_ctrl #(
   parameter int alen  = 32,
   parameter int depth = 1024,
   localparam int aw   = $clog2(depth)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bus_re,
   input  logic            bus_we,
   input  logic [1:0]      bus_asize,
   input  logic [alen-1:0] bus_addr,
   input  logic [31:0]     bus_wdata,
   output logic [31:0]     bus_rdata,
   output logic            bus_ready,
   output logic            bus_error,
   output logic            sram_en,
   output logic [3:0]      sram_we,
   output logic [aw-1:0]   sram_addr,
   output logic [31:0]     sram_wdata,
   input  logic [31:0]     sram_rdata
);

   typedef enum logic {IDLE, RDWAIT} state_t;

   state_t      state, state_nxt;
   logic [1:0]  addr_q, asize_q;
   logic        capture;

   logic        req, misalign, out_of_range, acc_err;
   logic [31:0] rd_shift;

   assign req = bus_re | bus_we;

   assign misalign = ((bus_asize == 2'd1) & bus_addr[0])
                   | ((bus_asize == 2'd2) & (|bus_addr[1:0]));

   // Every address bit above the SRAM word index must be zero.
   assign out_of_range = |(bus_addr >> (aw + 2));

   assign acc_err = (bus_re & bus_we) | (bus_asize == 2'd3) | misalign | out_of_range;

   assign rd_shift = sram_rdata >> {addr_q, 3'b000};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         asize_q <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            addr_q  <= bus_addr[1:0];
            asize_q <= bus_asize;
         end
      end
   end

   // Outputs are gated by rst so that an aborted read produces no ready.
   always_comb begin
      state_nxt  = state;
      capture    = 1'b0;
      bus_rdata  = '0;
      bus_ready  = 1'b0;
      bus_error  = 1'b0;
      sram_en    = 1'b0;
      sram_we    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (acc_err) begin
                     bus_ready = 1'b1;
                     bus_error = 1'b1;
                  end else if (bus_we) begin
                     sram_en   = 1'b1;
                     sram_addr = bus_addr[aw+1:2];
                     bus_ready = 1'b1;
                     case (bus_asize)
                        2'd0: begin
                           sram_we    = 4'b0001 << bus_addr[1:0];
                           sram_wdata = {4{bus_wdata[7:0]}};
                        end
                        2'd1: begin
                           sram_we    = 4'b0011 << bus_addr[1:0];
                           sram_wdata = {2{bus_wdata[15:0]}};
                        end
                        default: begin
                           sram_we    = 4'b1111;
                           sram_wdata = bus_wdata;
                        end
                     endcase
                  end else begin
                     sram_en   = 1'b1;
                     sram_addr = bus_addr[aw+1:2];
                     capture   = 1'b1;
                     state_nxt = RDWAIT;
                  end
               end
            end
            RDWAIT: begin
               state_nxt = IDLE;
               if (bus_re) begin
                  bus_ready = 1'b1;
                  case (asize_q)
                     2'd0:    bus_rdata = {24'd0, rd_shift[7:0]};
                     2'd1:    bus_rdata = {16'd0, rd_shift[15:0]};
                     default: bus_rdata = rd_shift;
                  endcase
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axo_mem_sram_ctrl.sv
module tb_axo_mem_sram_ctrl;

   localparam int DEPTH = 1024;
   localparam int NBYTE = DEPTH * 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_re = 1'b0, bus_we = 1'b0;
   logic [1:0]  bus_asize = 2'd0;
   logic [31:0] bus_addr = '0, bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        bus_ready, bus_error;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = '0;

   int checks = 0;
   int errors = 0;

   axo_mem_sram_ctrl #(.alen(32), .depth(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .bus_re(bus_re), .bus_we(bus_we), .bus_asize(bus_asize),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // External SRAM: byte-lane writes, one-cycle read latency.
   logic [31:0] sram_mem [DEPTH];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we == 4'd0) sram_rdata <= sram_mem[sram_addr];
         else
            for (int l = 0; l < 4; l++)
               if (sram_we[l]) sram_mem[sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a flat byte memory. A read that was accepted last cycle
   // returns its bytes now (when re is still held); otherwise every request is
   // judged from the access rules alone.
   logic [7:0]  ref_mem [NBYTE];
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_n;

   initial begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] = '0;
      for (int i = 0; i < NBYTE; i++) ref_mem[i] = '0;
      pend = 1'b0;
   end

   always @(negedge clk) begin
      logic [31:0] e_rdata, e_wdata, e_addr;
      logic        e_ready, e_error, e_en, bad;
      logic [3:0]  e_we;
      int          n;
      e_rdata = '0; e_wdata = '0; e_addr = '0;
      e_ready = 0; e_error = 0; e_en = 0; e_we = '0;
      if (rst) begin
         pend = 1'b0;
      end else if (pend) begin
         pend = 1'b0;
         e_ready = bus_re;
         if (bus_re)
            for (int i = 0; i < pend_n; i++)
               e_rdata = e_rdata | (32'(ref_mem[pend_addr + 32'(i)]) << (8*i));
      end else if (bus_re || bus_we) begin
         n = (bus_asize == 2'd3) ? 1 : (1 << bus_asize);
         bad = (bus_re && bus_we) || (bus_asize == 2'd3) ||
               ((bus_addr % 32'(n)) != 0) || (bus_addr >= 32'(NBYTE));
         if (bad) begin
            e_ready = 1; e_error = 1;
         end else if (bus_we) begin
            e_en = 1; e_ready = 1;
            e_addr = bus_addr / 4;
            e_we = 4'(((1 << n) - 1) << (bus_addr % 4));
            e_wdata = (n == 1) ? {4{bus_wdata[7:0]}} :
                      (n == 2) ? {2{bus_wdata[15:0]}} : bus_wdata;
            for (int i = 0; i < n; i++) ref_mem[bus_addr + 32'(i)] = bus_wdata[8*i +: 8];
         end else begin
            e_en = 1;
            e_addr = bus_addr / 4;
            pend = 1'b1; pend_addr = bus_addr; pend_n = n;
         end
      end
      chk("bus_ready", 32'(bus_ready), 32'(e_ready));
      chk("bus_error", 32'(bus_error), 32'(e_error));
      chk("bus_rdata", bus_rdata, e_rdata);
      chk("sram_en", 32'(sram_en), 32'(e_en));
      chk("sram_we", 32'(sram_we), 32'(e_we));
      chk("sram_addr", 32'(sram_addr), e_addr);
      chk("sram_wdata", sram_wdata, e_wdata);
   end

   // Runs one transfer and returns data, error, the cycle it completed in,
   // and the SRAM strobe/address seen in its first cycle.
   task automatic xfer(input logic re, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic en0, output logic [9:0] addr0);
      logic got;
      got = 0; rd = '0; er = 0; lat = -1; en0 = 0; addr0 = '0;
      bus_re = re; bus_we = we; bus_asize = sz; bus_addr = a; bus_wdata = wd;
      for (int c = 0; c < 4 && !got; c++) begin
         @(negedge clk);
         if (c == 0) begin en0 = sram_en; addr0 = sram_addr; end
         if (bus_ready) begin got = 1; rd = bus_rdata; er = bus_error; lat = c; end
         @(posedge clk); #1;
      end
      chk("xfer_timeout", 32'(got), 32'd1);
      bus_re = 0; bus_we = 0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er, en0;
      logic [9:0]  a0;
      int          lat;

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_ready", 32'(bus_ready), 32'd0);
      chk("reset_en", 32'(sram_en), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      xfer(0, 1, 2'd2, 32'h8, 32'h11223344, rd, er, lat, en0, a0);
      chk("wr_word_lat", 32'(lat), 32'd0);
      chk("wr_word_err", 32'(er), 32'd0);
      xfer(1, 0, 2'd2, 32'h8, 32'h0, rd, er, lat, en0, a0);
      chk("rd_word_lat", 32'(lat), 32'd1);
      chk("rd_word_data", rd, 32'h11223344);
      chk("rd_word_err", 32'(er), 32'd0);

      xfer(0, 1, 2'd0, 32'h9, 32'h000000AB, rd, er, lat, en0, a0);
      xfer(1, 0, 2'd2, 32'h8, 32'h0, rd, er, lat, en0, a0);
      chk("rd_after_byte_wr", rd, 32'h1122AB44);
      xfer(1, 0, 2'd0, 32'hB, 32'h0, rd, er, lat, en0, a0);
      chk("rd_byte_B", rd, 32'h00000011);
      xfer(1, 0, 2'd1, 32'hA, 32'h0, rd, er, lat, en0, a0);
      chk("rd_half_A", rd, 32'h00001122);

      xfer(0, 1, 2'd1, 32'h12, 32'hFFFFBEEF, rd, er, lat, en0, a0);
      xfer(1, 0, 2'd2, 32'h10, 32'h0, rd, er, lat, en0, a0);
      chk("rd_after_half_wr", rd, 32'hBEEF0000);

      xfer(1, 0, 2'd1, 32'h1, 32'h0, rd, er, lat, en0, a0);
      chk("mis_half_err", 32'(er), 32'd1);
      chk("mis_half_lat", 32'(lat), 32'd0);
      chk("mis_half_en", 32'(en0), 32'd0);
      xfer(1, 0, 2'd2, 32'h2, 32'h0, rd, er, lat, en0, a0);
      chk("mis_word_err", 32'(er), 32'd1);
      chk("mis_word_en", 32'(en0), 32'd0);
      xfer(1, 0, 2'd3, 32'h0, 32'h0, rd, er, lat, en0, a0);
      chk("asize3_err", 32'(er), 32'd1);
      xfer(1, 1, 2'd2, 32'h8, 32'h0, rd, er, lat, en0, a0);
      chk("re_we_err", 32'(er), 32'd1);
      xfer(0, 1, 2'd2, 32'h1000, 32'hDEADBEEF, rd, er, lat, en0, a0);
      chk("oor_wr_err", 32'(er), 32'd1);
      xfer(1, 0, 2'd2, 32'h1000, 32'h0, rd, er, lat, en0, a0);
      chk("oor_rd_err", 32'(er), 32'd1);
      xfer(0, 1, 2'd2, 32'hFFC, 32'hCAFEF00D, rd, er, lat, en0, a0);
      xfer(1, 0, 2'd2, 32'hFFC, 32'h0, rd, er, lat, en0, a0);
      chk("top_err", 32'(er), 32'd0);
      chk("top_sram_addr", 32'(a0), 32'd1023);
      chk("top_data", rd, 32'hCAFEF00D);

      // Back-to-back reads on 0, 4, 8 with re held throughout.
      xfer(0, 1, 2'd2, 32'h0, 32'hA0A0A0A0, rd, er, lat, en0, a0);
      xfer(0, 1, 2'd2, 32'h4, 32'hB1B1B1B1, rd, er, lat, en0, a0);
      bus_re = 1; bus_asize = 2'd2;
      for (int k = 0; k < 3; k++) begin
         bus_addr = 32'(4*k);
         @(negedge clk);
         chk("b2b_ready_even", 32'(bus_ready), 32'd0);
         chk("b2b_en_even", 32'(sram_en), 32'd1);
         @(posedge clk); #1;
         @(negedge clk);
         chk("b2b_ready_odd", 32'(bus_ready), 32'd1);
         chk("b2b_en_odd", 32'(sram_en), 32'd0);
         @(posedge clk); #1;
      end
      bus_re = 0;

      // Master drops re while the read is outstanding.
      bus_re = 1; bus_addr = 32'h8;
      @(posedge clk); #1;
      bus_re = 0;
      @(negedge clk);
      chk("drop_re_ready", 32'(bus_ready), 32'd0);
      @(posedge clk); #1;

      // Reset pulsed while a read is outstanding.
      bus_re = 1; bus_addr = 32'h8; bus_asize = 2'd2;
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      chk("rst_rdwait_ready", 32'(bus_ready), 32'd0);
      chk("rst_rdwait_rdata", bus_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 0; bus_re = 0;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus_ready), 32'd0);
      @(posedge clk); #1;
      xfer(1, 0, 2'd2, 32'h8, 32'h0, rd, er, lat, en0, a0);
      chk("post_rst_lat", 32'(lat), 32'd1);
      chk("post_rst_data", rd, 32'h1122AB44);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
